// File: rtl/ntt_frame_sequencer.sv
// Purpose : frame-level start sequencer for the streaming NTT stage chain.
// Latency : stageStart[s] fires 1+s*STAGE_LAT cycles after an accepted inStart; outStart fires TOTAL+1 cycles after it.
// Backpressure: none; the stage chain never stalls, and an early restart is dropped and flagged through protoErr.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   inStart           pulse on the first beat of an input frame
//   inBeat, inActive  position within the input frame currently being received
//   stageStart        bit s pulses when stage s sees its first beat
//   outStart, outBeat, outLast  output frame framing
//   inFlight          accepted frames whose outStart has not yet fired
//   busy              any input, in-flight frame or pending start in the delay line
//   protoErr          sticky flag: an inStart was rejected
module ntt_frame_sequencer #(
  parameter  int N          = 1024,
  parameter  int P          = 32,
  parameter  int NUM_STAGES = 10,
  parameter  int STAGE_LAT  = 4,
  localparam int BEATS      = N / P,
  localparam int BW         = (BEATS > 1) ? $clog2(BEATS) : 1,
  localparam int TOTAL      = NUM_STAGES * STAGE_LAT,
  localparam int FW         = $clog2(TOTAL / BEATS + 3)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inStart,
  output logic [BW-1:0]         inBeat,
  output logic                  inActive,
  output logic [NUM_STAGES-1:0] stageStart,
  output logic                  outStart,
  output logic [BW-1:0]         outBeat,
  output logic                  outLast,
  output logic [FW-1:0]         inFlight,
  output logic                  busy,
  output logic                  protoErr
);

  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  logic           acc;
  logic           preOut;
  logic           outActive;
  // Bit k holds an accepted start that was taken k+1 cycles ago.  A plain
  // shift register lets any number of overlapping frames ride the pipeline.
  logic [TOTAL:0] startPipe;

  // A restart is legal when idle or on the last beat of the current frame.
  assign acc = inStart & (~inActive | (inBeat == LAST_BEAT));

  // The tap just before outStart; used to open the output frame and retire
  // the in-flight count so both line up with the outStart cycle.
  assign preOut = startPipe[TOTAL-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      startPipe <= '0;
    end else begin
      startPipe <= {startPipe[TOTAL-1:0], acc};
    end
  end

  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_tap
    assign stageStart[s] = startPipe[s*STAGE_LAT];
  end
  assign outStart = startPipe[TOTAL];

  // Input frame counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      inActive <= 1'b0;
      inBeat   <= '0;
    end else if (acc) begin
      inActive <= 1'b1;
      inBeat   <= '0;
    end else if (inActive) begin
      if (inBeat == LAST_BEAT) begin
        inActive <= 1'b0;
        inBeat   <= '0;
      end else begin
        inBeat <= inBeat + 1'b1;
      end
    end
  end

  // Output frame counter; outBeat is 0 in the same cycle outStart is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      outActive <= 1'b0;
      outBeat   <= '0;
    end else if (preOut) begin
      outActive <= 1'b1;
      outBeat   <= '0;
    end else if (outActive) begin
      if (outBeat == LAST_BEAT) begin
        outActive <= 1'b0;
        outBeat   <= '0;
      end else begin
        outBeat <= outBeat + 1'b1;
      end
    end
  end

  assign outLast = outActive & (outBeat == LAST_BEAT);

  // Frames in flight: accept adds one, the pre-outStart tap removes one.
  always_ff @(posedge clk) begin
    if (rst) begin
      inFlight <= '0;
    end else if (acc && !preOut) begin
      inFlight <= inFlight + 1'b1;
    end else if (!acc && preOut) begin
      inFlight <= inFlight - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      protoErr <= 1'b0;
    end else if (inStart && !acc) begin
      protoErr <= 1'b1;
    end
  end

  assign busy = inActive | (inFlight != '0) | (|startPipe);

endmodule
